// File: rtl/nibble_pkg.sv
// Shared types for the nibble pair packer: nibble, packed pair, FSM state and FIFO entry.
package nibble_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned PAIR_W   = 2 * NIBBLE_W;
   localparam int unsigned FRAME_W  = 8;

   typedef logic [NIBBLE_W-1:0] uint4_t;

   typedef struct packed {
      uint4_t b;
      uint4_t a;
   } pair_t;

   typedef enum logic [0:0] {
      ST_LO = 1'b0,
      ST_HI = 1'b1
   } state_t;

   typedef struct packed {
      pair_t pair;
      logic  last;
      logic  odd;
   } entry_t;

endpackage

// File: rtl/nibble_pair_packer_if.sv
// Nibble input stream and packed-pair output stream; slave is the packer, master the peer.
interface nibble_pair_packer_if;
   import nibble_pkg::*;

   logic   in_valid;
   logic   in_ready;
   uint4_t in_nibble;
   logic   in_last;
   logic   out_valid;
   logic   out_ready;
   pair_t  out_pair;
   logic   out_last;
   logic   out_odd;

   modport slave (
      input  in_valid, in_nibble, in_last, out_ready,
      output in_ready, out_valid, out_pair, out_last, out_odd
   );

   modport master (
      output in_valid, in_nibble, in_last, out_ready,
      input  in_ready, out_valid, out_pair, out_last, out_odd
   );

endinterface

// File: rtl/nibble_fifo.sv
// Entry FIFO with wrap-bit pointers and a registered head, so full/valid/head are all flops.
module nibble_fifo
   import nibble_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_push,
   input  entry_t i_wdata,
   input  logic   i_pop,
   output logic   o_full,
   output logic   o_valid,
   output entry_t o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic            r_full;
   logic            r_valid;
   entry_t          r_head;

   logic            w_push_ok;
   logic            w_pop_ok;
   logic [PW-1:0]   w_wr_nxt;
   logic [PW-1:0]   w_rd_nxt;
   logic [AW-1:0]   w_rd_idx_nxt;
   logic [AW-1:0]   w_wr_idx;

   assign w_push_ok    = i_push && !r_full;
   assign w_pop_ok     = i_pop && r_valid;
   assign w_wr_nxt     = r_wr_ptr + PW'(w_push_ok);
   assign w_rd_nxt     = r_rd_ptr + PW'(w_pop_ok);
   assign w_rd_idx_nxt = w_rd_nxt[AW-1:0];
   assign w_wr_idx     = r_wr_ptr[AW-1:0];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[w_wr_idx] <= i_wdata;
      end
   end

   // Head for next cycle: the entry being written bypasses storage when it becomes the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_valid  <= 1'b0;
         r_head   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                     (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
         r_valid  <= (w_wr_nxt != w_rd_nxt);
         if (w_push_ok && (w_wr_idx == w_rd_idx_nxt)) begin
            r_head <= i_wdata;
         end else begin
            r_head <= r_mem[w_rd_idx_nxt];
         end
      end
   end

   assign o_full  = r_full;
   assign o_valid = r_valid;
   assign o_head  = r_head;

endmodule

// File: rtl/nibble_pair_packer.sv
// Packs a nibble stream into {b,a} byte pairs per frame, padding odd frames, and queues them.
module nibble_pair_packer
   import nibble_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_pair_packer_if.slave  bus,
   output logic [FRAME_W-1:0]   frame_count
);

   state_t              r_state;
   state_t              w_state_nxt;
   uint4_t              r_a;
   logic [FRAME_W-1:0]  r_frame_count;

   logic                w_accept;
   logic                w_push;
   logic                w_latch;
   entry_t              w_wdata;
   logic                w_full;
   logic                w_valid;
   entry_t              w_head;

   assign w_accept = bus.in_valid && !w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LO;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         case (r_state)
            ST_LO:   w_state_nxt = bus.in_last ? ST_LO : ST_HI;
            ST_HI:   w_state_nxt = ST_LO;
            default: w_state_nxt = ST_LO;
         endcase
      end
   end

   // A lone last nibble in ST_LO becomes an odd pair with zero padding in b.
   always_comb begin
      w_push  = 1'b0;
      w_latch = 1'b0;
      w_wdata = '0;
      if (w_accept) begin
         case (r_state)
            ST_LO: begin
               if (bus.in_last) begin
                  w_push         = 1'b1;
                  w_wdata.pair.b = '0;
                  w_wdata.pair.a = bus.in_nibble;
                  w_wdata.last   = 1'b1;
                  w_wdata.odd    = 1'b1;
               end else begin
                  w_latch = 1'b1;
               end
            end
            ST_HI: begin
               w_push         = 1'b1;
               w_wdata.pair.b = bus.in_nibble;
               w_wdata.pair.a = r_a;
               w_wdata.last   = bus.in_last;
               w_wdata.odd    = 1'b0;
            end
            default: begin
               w_push = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a           <= '0;
         r_frame_count <= '0;
      end else begin
         if (w_latch) begin
            r_a <= bus.in_nibble;
         end
         if (w_push && w_wdata.last) begin
            r_frame_count <= r_frame_count + FRAME_W'(1);
         end
      end
   end

   nibble_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (bus.out_ready),
      .o_full  (w_full),
      .o_valid (w_valid),
      .o_head  (w_head)
   );

   assign bus.in_ready  = !w_full;
   assign bus.out_valid = w_valid;
   assign bus.out_pair  = w_head.pair;
   assign bus.out_last  = w_head.last;
   assign bus.out_odd   = w_head.odd;
   assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_nibble_pair_packer.sv
// Scoreboard bench for nibble_pair_packer: directed frames, backpressure, reset and counter wrap.
module tb_nibble_pair_packer;
   import nibble_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] frame_count;
   int         n_checks = 0;
   int         n_errors = 0;

   logic [9:0] sb[$];
   logic       m_hi;
   logic [3:0] m_a;
   logic [7:0] m_frames;

   nibble_pair_packer_if ifc ();

   nibble_pair_packer #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (ifc),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference pairing model plus head comparison, evaluated mid-cycle for the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_hi     = 1'b0;
         m_a      = 4'h0;
         m_frames = 8'h00;
      end else begin
         chk("frame_count", 32'(frame_count), 32'(m_frames));
         if (ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 32'(ifc.out_pair), 32'hFFFF_FFFF);
            end else begin
               chk("head", 32'({ifc.out_pair, ifc.out_last, ifc.out_odd}), 32'(sb.pop_front()));
            end
         end
         if (ifc.in_valid && ifc.in_ready) begin
            if (m_hi) begin
               sb.push_back({ifc.in_nibble, m_a, ifc.in_last, 1'b0});
               if (ifc.in_last) m_frames = m_frames + 8'd1;
               m_hi = 1'b0;
            end else if (ifc.in_last) begin
               sb.push_back({4'h0, ifc.in_nibble, 1'b1, 1'b1});
               m_frames = m_frames + 8'd1;
            end else begin
               m_a  = ifc.in_nibble;
               m_hi = 1'b1;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [3:0] n, input logic last);
      int   waited = 0;
      logic got    = 1'b0;
      ifc.in_valid  = 1'b1;
      ifc.in_nibble = n;
      ifc.in_last   = last;
      while (!got && waited < 50) begin
         @(negedge clk);
         if (ifc.in_ready) got = 1'b1;
         cycle();
         waited++;
      end
      if (!got) chk("send_timeout", 32'(got), 32'd1);
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      ifc.out_ready = 1'b1;
      while ((sb.size() != 0 || ifc.out_valid) && waited < 100) begin
         cycle();
         waited++;
      end
      chk("drain_done", 32'(sb.size()), 32'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.in_nibble = 4'h0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b0;
      repeat (2) cycle();

      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_out_word", 32'({ifc.out_pair, ifc.out_last, ifc.out_odd}), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      rst = 1'b0;
      cycle();

      // Two-nibble frame: A5 appears one cycle after the second nibble is taken.
      ifc.out_ready = 1'b1;
      send(4'h5, 1'b0);
      chk("hi_no_push", 32'(ifc.out_valid), 32'd0);
      send(4'hA, 1'b1);
      chk("pair_valid", 32'(ifc.out_valid), 32'd1);
      chk("pair_a5", 32'(ifc.out_pair), 32'hA5);
      chk("pair_a5_last", 32'(ifc.out_last), 32'd1);
      chk("pair_a5_odd", 32'(ifc.out_odd), 32'd0);
      chk("pair_a5_frames", 32'(frame_count), 32'd1);
      cycle();

      // Odd frame: single nibble padded with zero.
      send(4'h7, 1'b1);
      chk("odd_pair", 32'(ifc.out_pair), 32'h07);
      chk("odd_flag", 32'(ifc.out_odd), 32'd1);
      chk("odd_last", 32'(ifc.out_last), 32'd1);
      drain();

      // Fill under backpressure: in_ready drops after the fourth pair.
      ifc.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(4'(i), (i == 8));
      chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("full_head", 32'(ifc.out_pair), 32'h21);
      repeat (3) cycle();
      chk("hold_head", 32'(ifc.out_pair), 32'h21);
      chk("hold_valid", 32'(ifc.out_valid), 32'd1);

      // Pop while full and in_valid high: no push that cycle, room afterwards.
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      ifc.in_nibble = 4'hB;
      ifc.in_last   = 1'b1;
      @(negedge clk);
      chk("full_pop_no_ready", 32'(ifc.in_ready), 32'd0);
      cycle();
      ifc.in_valid = 1'b0;
      chk("after_pop_ready", 32'(ifc.in_ready), 32'd1);
      chk("after_pop_head", 32'(ifc.out_pair), 32'h43);
      drain();

      // Reset mid-frame with a queued entry discards both.
      ifc.out_ready = 1'b0;
      send(4'h1, 1'b0);
      send(4'h2, 1'b1);
      send(4'h3, 1'b0);
      pulse_rst();
      chk("midrst_empty", 32'(ifc.out_valid), 32'd0);
      chk("midrst_ready", 32'(ifc.in_ready), 32'd1);
      chk("midrst_frames", 32'(frame_count), 32'd0);
      ifc.out_ready = 1'b1;
      send(4'h9, 1'b0);
      send(4'hC, 1'b1);
      chk("midrst_pair", 32'(ifc.out_pair), 32'hC9);
      drain();

      // 257 single-nibble frames wrap the frame counter to 1.
      pulse_rst();
      ifc.out_ready = 1'b1;
      for (int k = 0; k < 257; k++) send(4'(k), 1'b1);
      chk("wrap_frames", 32'(frame_count), 32'd1);
      drain();

      chk("sb_empty_end", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
